uart_echo_engine: RTL

Parametrised echo core between `uart_receiver` and `uart_transmitter` that replaces the hard-wired receiver→FIFO→transmitter chain of the echo top level. It owns its own buffer and adds run-time modes: plain echo, upper-case conversion, line-buffered echo (hold until carriage return), and mute. It also exports occupancy, line and drop statistics for LEDs or debug.

---
 rtl/uart_echo_engine.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_echo_engine.sv
// Echo core between the UART receiver and transmitter. It provides an internal circular
// buffer and four run-time modes: echo, upper-case, line-buffered and mute.
module uart_echo_engine #(
  parameter int          WIDTH    = 8,
  parameter int          LOGDEPTH = 4,
  parameter logic [7:0]  CR_CHAR  = 8'h0D
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic [WIDTH-1:0]    rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [WIDTH-1:0]    tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [LOGDEPTH:0]   fifo_count,
  output logic [LOGDEPTH:0]   line_count,
  output logic [15:0]         drop_count
);

  localparam int DEPTH = 2**LOGDEPTH;

  typedef enum logic [1:0] {
    MODE_ECHO  = 2'b00,
    MODE_UPPER = 2'b01,
    MODE_LINE  = 2'b10,
    MODE_MUTE  = 2'b11
  } mode_e;

  mode_e                cur_mode;
  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOGDEPTH-1:0]  wr_ptr, wr_ptr_next;
  logic [LOGDEPTH-1:0]  rd_ptr, rd_ptr_next;
  logic [LOGDEPTH:0]    count, count_next;
  logic [LOGDEPTH:0]    line_cnt, line_cnt_next;
  logic                 flush, flush_next;
  logic [15:0]          drop_cnt;

  logic                 full, empty;
  logic                 accept, store, rel;
  logic                 cr_in, cr_out;
  logic [WIDTH-1:0]     store_data;

  assign cur_mode = mode_e'(mode);

  // The count never exceeds DEPTH, so its top bit is set exactly when the buffer is full.
  assign full  = count[LOGDEPTH];
  assign empty = (count == '0);

  assign tx_data    = mem[rd_ptr];
  assign fifo_count = count;
  assign line_count = line_cnt;
  assign drop_count = drop_cnt;

  always_comb begin
    rx_ready = !full;
    tx_valid = !empty;
    if (cur_mode == MODE_MUTE) begin
      rx_ready = 1'b1;
    end
    if (cur_mode == MODE_LINE) begin
      tx_valid = !empty && ((line_cnt != '0) || flush);
    end
  end

  always_comb begin
    store_data = rx_data;
    if ((cur_mode == MODE_UPPER) && (rx_data[7:0] >= 8'h61) && (rx_data[7:0] <= 8'h7A)) begin
      store_data[5] = 1'b0;
    end
  end

  assign accept = rx_valid && rx_ready;
  assign store  = accept && (cur_mode != MODE_MUTE);
  assign rel    = tx_valid && tx_ready;
  assign cr_in  = store && (store_data[7:0] == CR_CHAR);
  assign cr_out = rel && (tx_data[7:0] == CR_CHAR);

  always_comb begin
    wr_ptr_next   = wr_ptr;
    rd_ptr_next   = rd_ptr;
    count_next    = count;
    line_cnt_next = line_cnt;
    flush_next    = flush;

    if (store) begin
      wr_ptr_next = wr_ptr + LOGDEPTH'(1);
    end
    if (rel) begin
      rd_ptr_next = rd_ptr + LOGDEPTH'(1);
    end

    case ({store, rel})
      2'b10:   count_next = count + (LOGDEPTH+1)'(1);
      2'b01:   count_next = count - (LOGDEPTH+1)'(1);
      default: count_next = count;
    endcase

    case ({cr_in, cr_out})
      2'b10:   line_cnt_next = line_cnt + (LOGDEPTH+1)'(1);
      2'b01:   line_cnt_next = line_cnt - (LOGDEPTH+1)'(1);
      default: line_cnt_next = line_cnt;
    endcase

    // A full buffer with no terminator would stall LINE mode forever; drain it all instead.
    if (full && (line_cnt == '0)) begin
      flush_next = 1'b1;
    end
    if (count_next == '0) begin
      flush_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      line_cnt <= '0;
      flush    <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wr_ptr   <= wr_ptr_next;
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      line_cnt <= line_cnt_next;
      flush    <= flush_next;
      if (accept && (cur_mode == MODE_MUTE) && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= store_data;
    end
  end

endmodule
